// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t        : fetch controller state encoding
//   fetch_entry_t        : {pc, instr} pair held in the fetch queues
//   INSTR_W              : instruction / address width
//   RESET_VECTOR_DEFAULT : first fetch address after reset
package fetch_pkg;

  localparam int          INSTR_W              = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle.
//   imem_req_valid/addr : fetch request (driven by the fetch unit)
//   imem_req_ready      : memory accepts the request
//   imem_rsp_valid/data : in-order instruction return, never back-pressured
// master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               imem_req_valid;
  logic [INSTR_W-1:0] imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch_entry_t.
//   push/din   : write an entry at the tail
//   pop/dout   : dout shows the head; pop advances it
//   clear      : empties the FIFO, overriding a same-cycle push or pop
//   count/empty/full : occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage between the PC register and instruction memory.
//   clk, rst (async, active-low)
//   pc_in / pc_next       : current PC in, next PC out (combinational)
//   imem (master)         : in-order fetch requests and responses
//   redirect_valid/_pc    : branch/jump redirect from execute
//   if_valid/instr/pc, if_ready : buffered instruction stream to decode
//   fetch_fault           : sticky misaligned-redirect flag
//
// state | meaning
// IDLE  | first cycle out of reset, pc_next = RESET_VECTOR
// RUN   | normal fetching under the credit limit
// FLUSH | discarding responses to requests issued before a redirect
// HALT  | misaligned redirect seen; frozen until reset
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          DEPTH        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] pc_in,
  output logic [INSTR_W-1:0] pc_next,
  instr_fetch_unit_if.master imem,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] if_pc,
  input  logic               if_ready,
  output logic               fetch_fault
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          fault_q, fault_d;

  logic          in_stream, redirect_ok, redirect_bad;
  logic          accept, rsp_take, rsp_drop, buf_pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] buf_count;
  fetch_entry_t  pend_din, pend_head, buf_din, buf_head;
  logic          buf_empty;
  logic [CW-1:0] pend_count_unused;
  logic          pend_empty_unused, pend_full_unused, buf_full_unused;
  logic [INSTR_W-1:0] pend_instr_unused;

  assign in_stream    = (state_q == RUN) || (state_q == FLUSH);
  assign redirect_ok  = in_stream && redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = in_stream && redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Buffered plus in-flight entries never exceed DEPTH, so the buffer cannot overflow.
  assign credit_used         = {1'b0, buf_count} + {1'b0, outstanding_q};
  assign imem.imem_req_valid = (state_q == RUN) && !redirect_valid &&
                               (credit_used < (CW+1)'(DEPTH));
  assign imem.imem_req_addr  = pc_in;

  assign accept   = imem.imem_req_valid && imem.imem_req_ready;
  // A zero outstanding count gates out responses to requests issued before a reset.
  assign rsp_take = (state_q == RUN) && imem.imem_rsp_valid && (outstanding_q != '0);
  assign rsp_drop = (state_q == FLUSH) && imem.imem_rsp_valid && (drop_q != '0);
  assign buf_pop  = if_valid && if_ready;

  assign pend_din          = '{pc: pc_in, instr: '0};
  assign buf_din           = '{pc: pend_head.pc, instr: imem.imem_rsp_data};
  assign pend_instr_unused = pend_head.instr;

  fetch_fifo #(.DEPTH(DEPTH)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (rsp_take),
    .clear (redirect_ok || redirect_bad),
    .din   (pend_din),
    .dout  (pend_head),
    .count (pend_count_unused),
    .empty (pend_empty_unused),
    .full  (pend_full_unused)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_take),
    .pop   (buf_pop),
    .clear (redirect_ok || redirect_bad),
    .din   (buf_din),
    .dout  (buf_head),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full_unused)
  );

  assign if_valid    = !buf_empty;
  assign if_instr    = buf_head.instr;
  assign if_pc       = buf_head.pc;
  assign fetch_fault = fault_q;

  always_comb begin
    pc_next = pc_in;
    if (state_q == IDLE)  pc_next = RESET_VECTOR;
    else if (redirect_ok) pc_next = redirect_pc;
    else if (accept)      pc_next = pc_in + 32'd4;
  end

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fault_d       = fault_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (accept)   outstanding_d = outstanding_d + 1'b1;
        if (rsp_take) outstanding_d = outstanding_d - 1'b1;
      end
      FLUSH: begin
        if (rsp_drop)      drop_d  = drop_q - 1'b1;
        if (drop_d == '0)  state_d = RUN;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (redirect_bad) begin
      state_d       = HALT;
      fault_d       = 1'b1;
      outstanding_d = '0;
      drop_d        = '0;
    end else if (redirect_ok) begin
      // outstanding_d already excludes a response consumed this cycle,
      // and no request can be accepted while a redirect is asserted.
      if (state_q == RUN) begin
        drop_d        = outstanding_d;
        outstanding_d = '0;
      end
      state_d = (drop_d == '0) ? RUN : FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      drop_q        <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fault_q       <= fault_d;
    end
  end

endmodule
